// File: rtl/otp_cipher_engine_if.sv
// rtl/otp_cipher_engine_if.sv - button/letter inputs and result outputs of the OTP cipher engine
interface otp_cipher_engine_if #(
    parameter int DEPTH = 8
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [4:0]       letter_in;
    logic             commit_btn;
    logic             mode_sel;
    logic             start_btn;
    logic             decrypt;
    logic [4:0]       out_char;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [CNT_W-1:0] msg_count;
    logic [CNT_W-1:0] key_count;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output letter_in, commit_btn, mode_sel, start_btn, decrypt,
        input  out_char, out_valid, out_idx, msg_count, key_count, busy, done, err
    );

    modport slave (
        input  letter_in, commit_btn, mode_sel, start_btn, decrypt,
        output out_char, out_valid, out_idx, msg_count, key_count, busy, done, err
    );
endinterface

// File: rtl/otp_cipher_engine.sv
// rtl/otp_cipher_engine.sv - one-time-pad letter cipher with message/key buffers
module otp_cipher_engine #(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    otp_cipher_engine_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [4:0]       SPACE = 5'd26;

    // Button history and post-reset masks
    logic commit_prev_q, start_prev_q;
    logic commit_mask_q, start_mask_q;
    logic commit_edge, start_edge;

    // Buffers
    logic [4:0] msg_mem_q [DEPTH];
    logic [4:0] key_mem_q [DEPTH];
    logic       wr_msg_en, wr_key_en;

    // Control and output state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] msg_count_q, msg_count_d;
    logic [CNT_W-1:0] key_count_q, key_count_d;
    logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
    logic             dec_q, dec_d;
    logic [4:0]       out_char_q, out_char_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Cipher datapath
    logic [4:0] cur_m, cur_k, key_eff;
    logic [5:0] sum6;
    logic [4:0] cipher_char;

    // A level held through reset release is masked until it drops, so it never looks like a press
    assign commit_edge = bus.commit_btn & ~commit_prev_q & ~commit_mask_q;
    assign start_edge  = bus.start_btn  & ~start_prev_q  & ~start_mask_q;

    // Button history registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_prev_q <= 1'b0;
            start_prev_q  <= 1'b0;
            commit_mask_q <= bus.commit_btn;
            start_mask_q  <= bus.start_btn;
        end else begin
            commit_prev_q <= bus.commit_btn;
            start_prev_q  <= bus.start_btn;
            commit_mask_q <= commit_mask_q & bus.commit_btn;
            start_mask_q  <= start_mask_q & bus.start_btn;
        end
    end

    assign cur_m   = msg_mem_q[rd_idx_q[IDX_W-1:0]];
    assign cur_k   = key_mem_q[rd_idx_q[IDX_W-1:0]];
    assign key_eff = (cur_k == SPACE) ? 5'd0 : cur_k;
    assign sum6    = {1'b0, cur_m} + {1'b0, key_eff};

    // Mod-26 add/subtract; results are always below 26 so the 5-bit wrap forms are exact
    always_comb begin
        cipher_char = cur_m;
        if (cur_m == SPACE) begin
            cipher_char = SPACE;
        end else if (!dec_q) begin
            cipher_char = (sum6 >= 6'd26) ? (cur_m + key_eff - 5'd26) : sum6[4:0];
        end else begin
            cipher_char = (cur_m >= key_eff) ? (cur_m - key_eff) : (cur_m + 5'd26 - key_eff);
        end
    end

    // Next-state logic for commits, run sequencing and result registers
    always_comb begin
        state_d     = state_q;
        msg_count_d = msg_count_q;
        key_count_d = key_count_q;
        rd_idx_d    = rd_idx_q;
        dec_d       = dec_q;
        out_char_d  = out_char_q;
        out_idx_d   = out_idx_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_msg_en   = 1'b0;
        wr_key_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start_edge) begin
                    // A same-cycle commit is silently dropped: start takes priority
                    if (msg_count_q == '0) begin
                        done_d = 1'b1;
                    end else if (key_count_q < msg_count_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        dec_d    = bus.decrypt;
                        rd_idx_d = '0;
                    end
                end else if (commit_edge) begin
                    if (bus.letter_in > SPACE) begin
                        err_d = 1'b1;
                    end else if (!bus.mode_sel) begin
                        if (msg_count_q == FULL) begin
                            err_d = 1'b1;
                        end else begin
                            wr_msg_en   = 1'b1;
                            msg_count_d = msg_count_q + 1'b1;
                        end
                    end else begin
                        if (key_count_q == FULL) begin
                            err_d = 1'b1;
                        end else begin
                            wr_key_en   = 1'b1;
                            key_count_d = key_count_q + 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (rd_idx_q < msg_count_q) begin
                    out_valid_d = 1'b1;
                    out_char_d  = cipher_char;
                    out_idx_d   = rd_idx_q[IDX_W-1:0];
                    rd_idx_d    = rd_idx_q + 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            msg_count_q <= '0;
            key_count_q <= '0;
            rd_idx_q    <= '0;
            dec_q       <= 1'b0;
            out_char_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_count_q <= msg_count_d;
            key_count_q <= key_count_d;
            rd_idx_q    <= rd_idx_d;
            dec_q       <= dec_d;
            out_char_q  <= out_char_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Buffer storage; a commit writes at the current count of its buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                msg_mem_q[i] <= '0;
                key_mem_q[i] <= '0;
            end
        end else begin
            if (wr_msg_en) begin
                msg_mem_q[msg_count_q[IDX_W-1:0]] <= bus.letter_in;
            end
            if (wr_key_en) begin
                key_mem_q[key_count_q[IDX_W-1:0]] <= bus.letter_in;
            end
        end
    end

    assign bus.out_char  = out_char_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.msg_count = msg_count_q;
    assign bus.key_count = key_count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_otp_cipher_engine.sv
// tb/tb_otp_cipher_engine.sv - scoreboard bench for otp_cipher_engine
module tb_otp_cipher_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    otp_cipher_engine_if #(.DEPTH(8)) ifc ();

    otp_cipher_engine #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_char_q [$];
    int exp_idx_q  [$];
    int m_buf      [$];
    int k_buf      [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int m, input int k, input bit dec);
        int kk;
        kk = (k == 26) ? 0 : k;
        if (m == 26) return 26;
        return dec ? ((m - kk + 26) % 26) : ((m + kk) % 26);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int c, input int i);
        exp_char_q.push_back(c);
        exp_idx_q.push_back(i);
    endtask

    task automatic push_model(input bit dec);
        for (int i = 0; i < m_buf.size(); i++) expect_out(model(m_buf[i], k_buf[i], dec), i);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        ifc.commit_btn = 1'b0;
        ifc.start_btn  = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        m_buf.delete();
        k_buf.delete();
        exp_char_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic commit(input int letter, input bit to_key);
        bit exp_err;
        ifc.letter_in  = letter[4:0];
        ifc.mode_sel   = to_key;
        ifc.commit_btn = 1'b1;
        tick;
        if (to_key) begin
            exp_err = (letter > 26) || (k_buf.size() == 8);
            if (!exp_err) k_buf.push_back(letter);
            chk("key_count", ifc.key_count, k_buf.size());
        end else begin
            exp_err = (letter > 26) || (m_buf.size() == 8);
            if (!exp_err) m_buf.push_back(letter);
            chk("msg_count", ifc.msg_count, m_buf.size());
        end
        chk("commit_err", ifc.err, exp_err);
        ifc.commit_btn = 1'b0;
        tick;
    endtask

    // Expectations must already be queued; decrypt is flipped after the start edge
    task automatic run(input bit dec, input bit with_commit);
        int cyc;
        int n;
        n = m_buf.size();
        ifc.decrypt   = dec;
        ifc.start_btn = 1'b1;
        if (with_commit) begin
            ifc.commit_btn = 1'b1;
            ifc.mode_sel   = 1'b0;
            ifc.letter_in  = 5'd4;
        end
        tick;
        chk("run_busy", ifc.busy, 1);
        chk("run_err", ifc.err, 0);
        ifc.start_btn  = 1'b0;
        ifc.commit_btn = 1'b0;
        ifc.decrypt    = ~dec;
        cyc = 1;
        while (ifc.done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        chk("done_latency", cyc, n + 2);
        chk("done_busy", ifc.busy, 1);
        chk("done_no_valid", ifc.out_valid, 0);
        chk("queue_drained", exp_char_q.size(), 0);
        tick;
        chk("busy_clear", ifc.busy, 0);
        chk("done_clear", ifc.done, 0);
        chk("msg_count_kept", ifc.msg_count, m_buf.size());
        chk("key_count_kept", ifc.key_count, k_buf.size());
    endtask

    // Scoreboard: every result beat must match the head of the expectation queue
    always @(negedge clk) begin
        int ec;
        int ei;
        if (rst === 1'b1 && ifc.out_valid === 1'b1) begin
            if (exp_char_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                ec = exp_char_q.pop_front();
                ei = exp_idx_q.pop_front();
                chk("out_char", ifc.out_char, ec);
                chk("out_idx", ifc.out_idx, ei);
            end
        end
    end

    initial begin
        int cyc;
        bit err_seen;

        // Reset with commit button held high through release
        ifc.letter_in  = 5'd3;
        ifc.mode_sel   = 1'b0;
        ifc.commit_btn = 1'b1;
        ifc.start_btn  = 1'b0;
        ifc.decrypt    = 1'b0;
        rst = 1'b0;
        tick;
        tick;
        chk("rst_msg_count", ifc.msg_count, 0);
        chk("rst_key_count", ifc.key_count, 0);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_char", ifc.out_char, 0);
        chk("rst_out_idx", ifc.out_idx, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_err", ifc.err, 0);
        rst = 1'b1;
        tick;
        tick;
        chk("held_btn_no_commit", ifc.msg_count, 0);
        chk("held_btn_no_err", ifc.err, 0);
        ifc.commit_btn = 1'b0;
        tick;
        commit(3, 0);

        // H + D encrypt with exact cycle timing
        do_reset;
        commit(7, 0);
        commit(3, 1);
        expect_out(10, 0);
        ifc.decrypt   = 1'b0;
        ifc.start_btn = 1'b1;
        tick;
        chk("e1_busy", ifc.busy, 1);
        chk("e1_no_valid", ifc.out_valid, 0);
        ifc.start_btn = 1'b0;
        tick;
        chk("e2_valid", ifc.out_valid, 1);
        chk("e2_char", ifc.out_char, 10);
        chk("e2_idx", ifc.out_idx, 0);
        tick;
        chk("e3_done", ifc.done, 1);
        chk("e3_busy", ifc.busy, 1);
        tick;
        chk("e4_idle", ifc.busy, 0);

        // Wraparound in both directions
        do_reset;
        commit(25, 0);
        commit(1, 1);
        expect_out(0, 0);
        run(0, 0);
        do_reset;
        commit(0, 0);
        commit(1, 1);
        expect_out(25, 0);
        run(1, 0);

        // Space passthrough; rerun of the same buffers in decrypt
        do_reset;
        commit(7, 0); commit(26, 0); commit(4, 0);
        commit(1, 1); commit(2, 1);  commit(3, 1);
        expect_out(8, 0); expect_out(26, 1); expect_out(7, 2);
        run(0, 0);
        expect_out(6, 0); expect_out(26, 1); expect_out(1, 2);
        run(1, 0);

        // Key space acts as zero shift; start+commit together drops the commit
        do_reset;
        commit(5, 0);
        commit(26, 1);
        expect_out(5, 0);
        run(0, 1);
        expect_out(5, 0);
        run(1, 0);

        // Too few keys, then empty message
        do_reset;
        commit(1, 0); commit(2, 0); commit(3, 0);
        commit(1, 1); commit(2, 1);
        ifc.start_btn = 1'b1;
        tick;
        chk("short_key_err", ifc.err, 1);
        chk("short_key_busy", ifc.busy, 0);
        ifc.start_btn = 1'b0;
        tick;
        chk("short_key_err_pulse", ifc.err, 0);
        chk("short_key_idle", ifc.busy, 0);
        do_reset;
        ifc.start_btn = 1'b1;
        tick;
        chk("empty_done", ifc.done, 1);
        chk("empty_busy", ifc.busy, 0);
        chk("empty_err", ifc.err, 0);
        ifc.start_btn = 1'b0;
        tick;
        chk("empty_done_pulse", ifc.done, 0);

        // Full buffers, overflow, invalid letter, ignored presses during a run
        do_reset;
        for (int i = 0; i < 9; i++) commit($urandom_range(0, 26), 0);
        commit(28, 1);
        for (int i = 0; i < 8; i++) commit($urandom_range(0, 26), 1);
        commit(5, 1);
        push_model(0);
        ifc.decrypt   = 1'b0;
        ifc.start_btn = 1'b1;
        tick;
        err_seen = (ifc.err === 1'b1);
        ifc.start_btn  = 1'b0;
        ifc.commit_btn = 1'b1;
        ifc.letter_in  = 5'd2;
        ifc.mode_sel   = 1'b0;
        tick;
        err_seen |= (ifc.err === 1'b1);
        ifc.start_btn = 1'b1;
        tick;
        ifc.start_btn  = 1'b0;
        ifc.commit_btn = 1'b0;
        cyc = 3;
        while (ifc.done !== 1'b1 && cyc < 40) begin
            err_seen |= (ifc.err === 1'b1);
            tick;
            cyc++;
        end
        chk("full_done_latency", cyc, 10);
        chk("full_no_err", err_seen, 0);
        chk("full_queue_drained", exp_char_q.size(), 0);
        chk("full_msg_count", ifc.msg_count, 8);
        tick;
        chk("full_busy_clear", ifc.busy, 0);
        push_model(1);
        run(1, 0);

        // Reset during the second output cycle of a 4-character run
        do_reset;
        for (int i = 0; i < 4; i++) commit(i + 1, 0);
        for (int i = 0; i < 4; i++) commit(i + 10, 1);
        push_model(0);
        ifc.start_btn = 1'b1;
        tick;
        ifc.start_btn = 1'b0;
        tick;
        tick;
        chk("abort_second_valid", ifc.out_valid, 1);
        rst = 1'b0;
        tick;
        exp_char_q.delete();
        exp_idx_q.delete();
        chk("abort_out_valid", ifc.out_valid, 0);
        chk("abort_out_char", ifc.out_char, 0);
        chk("abort_msg_count", ifc.msg_count, 0);
        chk("abort_key_count", ifc.key_count, 0);
        chk("abort_busy", ifc.busy, 0);
        rst = 1'b1;
        err_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            err_seen |= (ifc.done === 1'b1);
            tick;
        end
        chk("abort_no_done", err_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/otp_cipher_engine.md
OTP_CIPHER_ENGINE -- requirements
Module: otp_cipher_engine

Interface
REQ-001 Parameter DEPTH, default 8, meaning max characters held in each of the message and key buffers.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 letter_in  input  5  letter index from upstream counter; 0..25 = A..Z, 26 = space, 27..31 invalid.
REQ-005 commit_btn  input  1  level button; rising edge stores letter_in into the selected buffer.
REQ-006 mode_sel  input  1  0 = commit goes to message buffer, 1 = commit goes to key buffer.
REQ-007 start_btn  input  1  level button; rising edge launches a cipher run.
REQ-008 decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on the start edge and held for the run.
REQ-009 out_char  output  5  result character index, valid when out_valid=1.
REQ-010 out_valid  output  1  one cycle per result character.
REQ-011 out_idx  output  clog2(DEPTH)  buffer position of out_char.
REQ-012 msg_count, key_count  output  clog2(DEPTH)+1 each  characters stored per buffer.
REQ-013 busy  output  1  high while a run is in progress.
REQ-014 done  output  1  one-cycle pulse at end of run.
REQ-015 err  output  1  one-cycle pulse on any rejected request.

Function
REQ-016 Edge detect SHALL use a registered previous sample per button; edge cycle E = cycle where button=1 and previous sample=0.
REQ-017 FSM states IDLE, RUN, DONE; commits accepted only in IDLE; commits during RUN/DONE ignored, no err.
REQ-018 Commit in IDLE with letter_in<=26 and selected count<DEPTH: write at index count, increment count at E+1.
REQ-019 Commit with letter_in>=27: no write, err pulse at E+1.
REQ-020 Commit with selected count==DEPTH (full): no write, count unchanged, err pulse at E+1.
REQ-021 Start edge in IDLE with key_count<msg_count: no run, err pulse at E+1, stays IDLE.
REQ-022 Start edge in IDLE with msg_count==0: done pulse at E+1, no out_valid, stays IDLE.
REQ-023 Otherwise start edge: latch decrypt, enter RUN at E+1; busy=1 from E+1 through the done cycle.
REQ-024 RUN: one character per cycle, index 0..msg_count-1 in order; out_valid/out_char/out_idx registered, first at E+2, consecutive, no gaps.
REQ-025 After last character, DONE for one cycle: done=1, busy=1, out_valid=0; then IDLE.
REQ-026 Start and commit edges in the same IDLE cycle: start processed, commit dropped without err.
REQ-027 Start edge during RUN/DONE ignored.
REQ-028 Arithmetic uses 6-bit intermediate; key value 26 treated as 0.
REQ-029 Encrypt: s=m+k; out = s-26 if s>=26 else s.
REQ-030 Decrypt: out = m-k if m>=k else m+26-k.
REQ-031 Message char 26 (space) passes through as 26 in both modes; key position still consumed.
REQ-032 Buffers and counts SHALL be unchanged by a run; a new run may reuse them.
REQ-033 No clear other than rst; reloading requires reset.

Reset
REQ-034 rst=0 at a clock edge: FSM->IDLE, msg_count=key_count=0, out_char=0, out_idx=0, out_valid=0, busy=0, done=0, err=0, button history registers=0, buffer contents=0.
REQ-035 Reset mid-run aborts immediately; no further out_valid or done.
REQ-036 Button held high through reset release does not produce an edge.

Verification
REQ-037 Commit msg H(7), key D(3), encrypt start -> out_valid at E+2 with out_char=10 (K), out_idx=0; done at E+3.
REQ-038 Msg Z(25), key B(1), encrypt -> 0 (A); msg A(0), key B(1), decrypt -> 25 (Z).
REQ-039 Msg [7,26,4], key [1,2,3], encrypt -> 8, 26, 7 on three consecutive cycles, idx 0,1,2; key entry 26 with msg 5 -> 5.
REQ-040 Nine message commits with DEPTH=8 -> msg_count=8, err pulse on ninth; commit letter_in=28 -> err, count unchanged.
REQ-041 msg_count=3, key_count=2, start -> err pulse, no out_valid, busy stays 0; msg_count=0, start -> done only.
REQ-042 rst=0 during second output cycle of a 4-char run -> all outputs 0 next cycle, counts 0, no done.
